timer_irq: RTL
==============

# timer_irq

Programmable down-counting timer that raises a hardware interrupt line toward the coprocessor's `HWInt` inputs. It is the source end of the interrupt path. It sits on the CPU's memory-mapped device bus as a word-addressed peripheral with three registers: CTRL, PRESET and COUNT. It supports a one-shot mode with a sticky interrupt and an auto-reload mode with a one-cycle interrupt pulse.

## Interface
- `RESET_PRESET`, default 32'h0: PRESET value after reset.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `addr` input 2: word address (bus byte address [3:2]); 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- `we` input 1: bus write strobe, sampled on the rising edge.
- `din` input 32: bus write data.
- `dout` output 32: combinational read data of the register selected by `addr`; unmapped reads 0.
- `irq` output 1: interrupt request, intended for one `HWInt` bit.

## Operation
- CTRL register fields:
  - [0] EN: count enable.
  - [2:1] MODE: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00 but read back as written.
  - [3] IM: interrupt mask, 1 = irq enabled.
  - [31:4] read as 0 and ignore writes.
- PRESET: 32-bit reload value, fully read/write.
- COUNT: 32-bit, read-only; writes to addr 2 or 3 are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1 go to LOAD; otherwise hold.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE (COUNT holds).
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1), COUNT <= 0, set `irq_pend`, go to INT.
  - INT:
    - One-shot: EN <= 0, go to IDLE.
    - Auto-reload: clear `irq_pend`, go to LOAD.
- `irq = irq_pend & IM`. The mask gates only the output, never `irq_pend`.
- One-shot `irq_pend` stays set until any bus write to CTRL or PRESET clears it.
- Bus write vs FSM in the same cycle: a bus write to CTRL takes precedence over the FSM's EN clear in INT.
- A PRESET write during CNT does not affect the running COUNT; it takes effect at the next LOAD.
- Clearing EN during LOAD still completes the load; the FSM then exits CNT to IDLE on the next edge.
- COUNT never wraps below 0.
- Reset (asynchronous, any state including mid-count) sets:
  - CTRL = 0, PRESET = RESET_PRESET, COUNT = 0.
  - FSM in IDLE, `irq_pend` = 0, therefore `irq` = 0.
  - `dout` reflects the reset register values.

## Timing
- Edge numbering: CTRL write with EN=1 lands at edge e0.
  - e1: IDLE→LOAD.
  - e2: COUNT = PRESET = N, state CNT.
  - For N ≥ 2: COUNT reaches 1 at e(N+1); at e(N+2) COUNT = 0, state INT, and `irq` rises (if IM=1).
  - For N ∈ {0, 1}: INT at e3.
- Latency from enable write to `irq` is N+2 edges for N ≥ 2.
- Auto-reload:
  - `irq` is high for exactly one cycle, from e(N+2) to e(N+3).
  - Period between successive rising edges of `irq` is N+2 cycles (minimum 3).
- One-shot: EN reads 0 after e(N+3); `irq` stays high until a CTRL/PRESET write edge, then drops on that edge.
- `dout` is combinational; COUNT reads reflect the value after the most recent edge.

## Test plan
- Reset mid-count: PRESET=100, CTRL=0x9, assert `reset` asynchronously at COUNT=50 → CTRL, COUNT and `irq` read 0 immediately, before the next clock edge.
- One-shot: PRESET=5, CTRL=0x9 at e0 → `irq` rises at e7; CTRL reads 0x8 after e8; `irq` stays high 20 cycles; CTRL write 0x8 → `irq` low on that edge.
- Auto-reload: PRESET=3, CTRL=0xB → `irq` one-cycle pulses at e5, e10, e15 (period 5); COUNT sequence 3, 2, 1, 0, then reloads to 3.
- Mask: PRESET=2, CTRL=0x1 (IM=0) → `irq` never rises, COUNT reaches 0, EN cleared; then write CTRL=0x8 → `irq` stays 0 because the write cleared `irq_pend`.
- Boundaries: PRESET=0 and PRESET=1 each give INT at e3; PRESET=32'hFFFFFFFF decrements without wrap (COUNT after e3 = 32'hFFFFFFFE).
- Bus edge cases:
  - Write to COUNT is ignored.
  - Read of addr 3 returns 0.
  - CTRL write 0xFFFFFFF0 reads back 0.
  - PRESET write during CNT leaves COUNT unchanged until the next reload.
  - EN cleared mid-count → IDLE with COUNT frozen.

Source files
------------

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped down-counting timer that drives one interrupt line.
// Registers: 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET, 2 = COUNT (read-only), 3 = unmapped.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | stopped; waits for EN to start a run
// LOAD  | copies PRESET into COUNT
// CNT   | decrements COUNT while EN is set; raises irq_pend at 0/1
// INT   | one-shot: clears EN and stops; auto-reload: drops pend and reloads
module timer_irq #(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  state_t      state_q, state_d;
  logic        ctrl_en, ctrl_im;
  logic [1:0]  ctrl_mode;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_d;
  logic        irq_pend;
  logic        pend_set, pend_clr, en_clr;
  logic        wr_ctrl, wr_preset;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  // FSM state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state, counter update and pend/EN side effects
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = LOAD;
      end
      LOAD: begin
        // Load completes even if EN was just cleared; CNT then exits to IDLE.
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Terminal count: 0 and 1 both land on 0 so COUNT never wraps.
          count_d  = 32'd0;
          pend_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (ctrl_mode == MODE_AUTO) begin
          pend_clr = 1'b1;
          state_d  = LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // CTRL register; a bus write wins over the FSM's one-shot EN clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en   <= din[0];
      ctrl_mode <= din[2:1];
      ctrl_im   <= din[3];
    end else if (en_clr) begin
      ctrl_en   <= 1'b0;
    end
  end

  // PRESET register; only sampled by LOAD, so writes never disturb a running count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset_q <= RESET_PRESET;
    end else if (wr_preset) begin
      preset_q <= din;
    end
  end

  // Pending flag: set at terminal count, cleared by reload or any CTRL/PRESET write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pend <= 1'b0;
    end else if (pend_set) begin
      irq_pend <= 1'b1;
    end else if (pend_clr || wr_ctrl || wr_preset) begin
      irq_pend <= 1'b0;
    end
  end

  // Mask gates only the output line, never the pending flag
  assign irq = irq_pend & ctrl_im;

  // Combinational read mux
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = 32'd0;
    endcase
  end

endmodule
